// File: rtl/hand_shake_pkg.sv
// Shared definitions for the handshake TX arbiter slice:
// FSM encoding, default word width and a clog2 helper.
package hand_shake_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } hs_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_rr_arbiter.sv
// Combinational round-robin picker: first asserted request
// at or above the pointer, wrapping past the top index.
module hs_rr_arbiter
    import hand_shake_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    int unsigned    cand;
    logic [IDW-1:0] cand_idx;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr_i) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hand_shake_tx_arbiter.sv
// Round-robin sharing of one full-handshake CDC transmitter,
// with a per-phase watchdog and a completed-transfer counter.
module hand_shake_tx_arbiter
    import hand_shake_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int unsigned TIMEOUT_CYC = 1024,
    parameter  int unsigned CNT_WIDTH   = 16,
    localparam int unsigned IDW         = clog2(NUM_REQ)
) (
    input  logic                          iTxClk,
    input  logic                          iRstTx,
    input  logic [NUM_REQ-1:0]            iReqValid,
    output logic [NUM_REQ-1:0]            oReqReady,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData,
    output logic                          oHsValid,
    output logic [DATA_WIDTH-1:0]         oHsData,
    input  logic                          iHsBusy,
    output logic [IDW-1:0]                oGrantId,
    output logic                          oBusy,
    output logic                          oTimeout,
    output logic [CNT_WIDTH-1:0]          oXferCnt
);

    localparam int unsigned WDW = clog2(TIMEOUT_CYC);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYC - 1);

    hs_state_e             state_q;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        gnt_id_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  tmo_q;
    logic [WDW-1:0]        wdog_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDW-1:0]        arb_idx;
    logic                  arb_any;
    logic                  arb_fire;
    logic [IDW-1:0]        ptr_d;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wd_hit;

    hs_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req_i(iReqValid),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx),
        .any_o(arb_any)
    );

    // A grant is only offered while idle and the transmitter is free.
    assign arb_fire  = (state_q == IDLE) && !iHsBusy && arb_any;
    assign oReqReady = arb_fire ? arb_gnt : '0;
    assign ptr_d     = (arb_idx == IDW'(NUM_REQ - 1)) ?
                       '0 : arb_idx + IDW'(1);
    assign wd_hit    = (wdog_q == WD_LIMIT);

    // Pick the winning requester's word with a one-hot mux.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = iReqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transfer FSM with latch, watchdog, counter and pointer.
    always_ff @(posedge iTxClk) begin
        if (iRstTx) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            wdog_q   <= '0;
            cnt_q    <= '0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (arb_fire) begin
                        data_q   <= sel_data;
                        gnt_id_q <= arb_idx;
                        ptr_q    <= ptr_d;
                        valid_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iHsBusy) begin
                        valid_q <= 1'b0;
                        wdog_q  <= '0;
                        state_q <= WAIT_DONE;
                    end else if (wd_hit) begin
                        valid_q <= 1'b0;
                        tmo_q   <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!iHsBusy) begin
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else if (wd_hit) begin
                        tmo_q   <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    wdog_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oHsValid = valid_q;
    assign oHsData  = data_q;
    assign oGrantId = gnt_id_q;
    assign oBusy    = (state_q != IDLE);
    assign oTimeout = tmo_q;
    assign oXferCnt = cnt_q;

endmodule

// File: doc/hand_shake_tx_arbiter.md
Name: hand_shake_tx_arbiter

Overview:
- Shares one full-handshake CDC transmit channel between N requesters in the TX clock domain.
- Picks a requester round-robin, latches its word, and drives the transmitter's valid/data inputs.
- Tracks the transmitter's busy indication until the far-side acknowledge completes, then serves the next requester.
- Adds a per-phase timeout watchdog and a completed-transfer counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, width of each data word.
- TIMEOUT_CYC, 1024, maximum cycles allowed per handshake phase before abort (>=4).
- CNT_WIDTH, 16, width of the transfer counter.

Ports:
- iTxClk  in  1  TX-domain clock.
- iRstTx  in  1  synchronous, active-high reset.
- iReqValid  in  NUM_REQ  per-requester request, level.
- oReqReady  out  NUM_REQ  per-requester accept strobe; word taken on valid&ready.
- iReqData  in  NUM_REQ*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- oHsValid  out  1  data-valid to the handshake transmitter.
- oHsData  out  DATA_WIDTH  word to the handshake transmitter; held stable from ISSUE through WAIT_DONE.
- iHsBusy  in  1  transmitter ready/busy flag: high while a transfer is in flight, low after the receive ack returns.
- oGrantId  out  clog2(NUM_REQ)  index of the current/last granted requester.
- oBusy  out  1  high in any state other than IDLE.
- oTimeout  out  1  one-cycle pulse on watchdog abort.
- oXferCnt  out  CNT_WIDTH  count of completed transfers; wraps.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0 (requester 0 has highest priority first); watchdog 0.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, arbitration:
  - Arbitration occurs only when iHsBusy==0 and at least one iReqValid is high.
  - The winner is the first valid index searching from the pointer upward with wrap.
  - oReqReady[winner] is high combinationally in that cycle, one-hot; every other ready bit is 0.
  - At the clock edge: iReqData slice latched into oHsData, oGrantId set to winner, pointer set to winner+1 mod NUM_REQ, state goes to ISSUE.
- ISSUE:
  - oHsValid=1 and held.
  - When iHsBusy is sampled 1: oHsValid drops next cycle, state goes to WAIT_DONE, watchdog clears.
- WAIT_DONE:
  - oHsValid=0.
  - When iHsBusy is sampled 0: oXferCnt increments (wraps at 2^CNT_WIDTH), state goes to IDLE.
  - Earliest next grant is the cycle after returning to IDLE, so there is a minimum 1-cycle idle gap between transfers.
- Watchdog:
  - Counts cycles spent in ISSUE or WAIT_DONE and clears on every state change.
  - Reaching TIMEOUT_CYC-1 without the exit condition: oTimeout pulses 1 cycle, oHsValid=0, state goes to IDLE, oXferCnt unchanged, pointer keeps the advanced value.
  - The aborted word is dropped; the requester must re-request.
- Stuck busy: if iHsBusy stays high after a timeout, IDLE does not arbitrate and no ready is asserted until it falls.
- Requester drops iReqValid while not granted: no effect; no grant.
- Single requester: served back-to-back.
- All requesters valid continuously: strict rotation 0,1,2,3,0,...
- Reset mid-operation:
  - Arbiter returns to reset values immediately at the clock edge.
  - An in-flight transmitter transfer is not cancelled; IDLE waits for iHsBusy==0 before the next grant.
- Latency: iReqValid rising while idle with iHsBusy=0 gives ready in the same cycle and oHsValid the next cycle.

Decomposition:
- Package hand_shake_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2);
  - a clog2 function;
  - the default DATA_WIDTH.
- Sub-module hs_rr_arbiter:
  - combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-request flag.
- FSM, data latch, watchdog and counter stay in hand_shake_tx_arbiter.

Test Plan:
- Reset then iReqValid=4'b0100 with data 0xA5 in slice 2; bench models busy high 3 cycles after oHsValid, low 10 cycles later. Required: oReqReady=4'b0100 for exactly 1 cycle, oHsData=0xA5, oGrantId=2, oXferCnt=1.
- All four valid continuously, data = index+1, bench model as above, 8 transfers. Required: oGrantId sequence 0,1,2,3,0,1,2,3; oHsData 1,2,3,4,1,2,3,4; oXferCnt=8.
- iHsBusy tied 0 with TIMEOUT_CYC=16. Required: oTimeout pulses after 16 cycles in ISSUE, state IDLE, oXferCnt=0; next request is granted to the next pointer.
- iHsBusy raised and held high. Required: one oTimeout from WAIT_DONE, then no oReqReady while busy stays high; first grant occurs the cycle after busy falls.
- iRstTx asserted for 1 cycle during WAIT_DONE. Required: outputs 0, pointer 0; no grant until iHsBusy falls.
- Force oXferCnt to 16'hFFFF, then one transfer. Required: 16'h0000.
